// File: rtl/u_xmit_if.sv
// Parallel-side handshake and serial line of the u_xmit UART transmitter.
interface u_xmit_if;
  logic [7:0] xmit_dataH;
  logic       xmitH;
  logic       uart_xmitH;
  logic       xmit_busyH;
  logic       xmit_doneH;

  modport master (
    output xmit_dataH,
    output xmitH,
    input  uart_xmitH,
    input  xmit_busyH,
    input  xmit_doneH
  );

  modport slave (
    input  xmit_dataH,
    input  xmitH,
    output uart_xmitH,
    output xmit_busyH,
    output xmit_doneH
  );
endinterface

// File: rtl/u_xmit.sv
// UART transmitter: start bit, WORD_LEN data bits LSB first, optional parity, stop bit(s).
// Runs on sys_clk at BIT_CYCLES clocks per serial bit; all outputs registered.
module u_xmit #(
  parameter int unsigned WORD_LEN   = 8,
  parameter int unsigned BIT_CYCLES = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input logic     sys_clk,
  input logic     sys_rst,
  u_xmit_if.slave xbus
);

  typedef enum logic [2:0] {
    XIdle   = 3'd0,
    XStart  = 3'd1,
    XData   = 3'd2,
    XParity = 3'd3,
    XStop   = 3'd4
  } state_t;

  localparam logic [7:0] DataMask = 8'((16'd1 << WORD_LEN) - 16'd1);
  localparam logic [3:0] CellLast = 4'(BIT_CYCLES - 1);
  localparam logic [2:0] WordLast = 3'(WORD_LEN - 1);
  localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);

  state_t     stateQ, stateD;
  logic [3:0] cellCntQ, cellCntD;
  logic [2:0] bitCntQ, bitCntD;
  logic [7:0] shiftQ, shiftD;
  logic       parityQ, parityD;
  logic       lineQ, lineD;
  logic       busyQ, busyD;
  logic       doneQ, doneD;

  logic       cellEnd;
  logic [7:0] maskedData;

  assign cellEnd    = (cellCntQ == CellLast);
  assign maskedData = xbus.xmit_dataH & DataMask;

  always_comb begin
    stateD   = stateQ;
    cellCntD = 4'(cellCntQ + 4'd1);
    bitCntD  = bitCntQ;
    shiftD   = shiftQ;
    parityD  = parityQ;
    lineD    = lineQ;
    busyD    = busyQ;
    doneD    = 1'b0;

    case (stateQ)
      XIdle: begin
        cellCntD = 4'd0;
        bitCntD  = 3'd0;
        lineD    = 1'b1;
        busyD    = 1'b0;
        if (xbus.xmitH) begin
          stateD  = XStart;
          shiftD  = maskedData;
          parityD = (^maskedData) ^ 1'(PARITY_ODD);
          lineD   = 1'b0;
          busyD   = 1'b1;
        end
      end

      XStart: begin
        if (cellEnd) begin
          cellCntD = 4'd0;
          bitCntD  = 3'd0;
          stateD   = XData;
          lineD    = shiftQ[0];
        end
      end

      XData: begin
        if (cellEnd) begin
          cellCntD = 4'd0;
          shiftD   = {1'b0, shiftQ[7:1]};
          if (bitCntQ == WordLast) begin
            bitCntD = 3'd0;
            if (PARITY_EN != 0) begin
              stateD = XParity;
              lineD  = parityQ;
            end else begin
              stateD = XStop;
              lineD  = 1'b1;
            end
          end else begin
            bitCntD = 3'(bitCntQ + 3'd1);
            lineD   = shiftQ[1];
          end
        end
      end

      XParity: begin
        if (cellEnd) begin
          cellCntD = 4'd0;
          bitCntD  = 3'd0;
          stateD   = XStop;
          lineD    = 1'b1;
        end
      end

      XStop: begin
        if (cellEnd) begin
          cellCntD = 4'd0;
          if (bitCntQ == StopLast) begin
            bitCntD = 3'd0;
            doneD   = 1'b1;
            // A request on the completion edge starts the next frame with no idle gap.
            if (xbus.xmitH) begin
              stateD  = XStart;
              shiftD  = maskedData;
              parityD = (^maskedData) ^ 1'(PARITY_ODD);
              lineD   = 1'b0;
              busyD   = 1'b1;
            end else begin
              stateD = XIdle;
              lineD  = 1'b1;
              busyD  = 1'b0;
            end
          end else begin
            bitCntD = 3'(bitCntQ + 3'd1);
          end
        end
      end

      default: begin
        stateD   = XIdle;
        cellCntD = 4'd0;
        bitCntD  = 3'd0;
        lineD    = 1'b1;
        busyD    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      stateQ   <= XIdle;
      cellCntQ <= 4'd0;
      bitCntQ  <= 3'd0;
      shiftQ   <= 8'd0;
      parityQ  <= 1'b0;
      lineQ    <= 1'b1;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cellCntQ <= cellCntD;
      bitCntQ  <= bitCntD;
      shiftQ   <= shiftD;
      parityQ  <= parityD;
      lineQ    <= lineD;
      busyQ    <= busyD;
      doneQ    <= doneD;
    end
  end

  assign xbus.uart_xmitH = lineQ;
  assign xbus.xmit_busyH = busyQ;
  assign xbus.xmit_doneH = doneQ;

endmodule

// File: doc/u_xmit.md
Name: u_xmit

Overview:
- UART transmitter; the transmit-side counterpart of the existing u_rec receiver, running on the same sys_clk (16x the bit rate).
- Serializes one parallel byte per request onto uart_xmitH: start bit, WORD_LEN data bits LSB first, optional parity, stop bit(s).
- Frames are decodable by u_rec with default parameters; the bench pairs the two blocks for loopback.

Parameters:
- WORD_LEN, 8, data bits per frame (5..8).
- BIT_CYCLES, 16, sys_clk cycles per serial bit (2..16). Bit-cell counter is 4 bits.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- sys_clk, in, 1, system clock; one clock for the whole block.
- sys_rst, in, 1, asynchronous, active-high reset.
- xmit_dataH, in, 8, byte to send; bits [WORD_LEN-1:0] are used.
- xmitH, in, 1, transmit request; sampled on the rising edge of sys_clk.
- uart_xmitH, out, 1, serial line; idles high.
- xmit_busyH, out, 1, high while a frame is in progress.
- xmit_doneH, out, 1, one-cycle pulse when a frame completes.

Behaviour:
- Reset (asynchronous assert):
  - Outputs: uart_xmitH=1, xmit_busyH=0, xmit_doneH=0.
  - State=X_IDLE; bit-cell counter, bit counter and shift register cleared.
- Reset asserted mid-frame: the line returns high immediately and the frame is abandoned. No xmit_doneH pulse.
- Accept rule:
  - xmitH=1 with xmit_busyH=0 at a clock edge captures xmit_dataH into the shift register and computes parity from the captured bits.
  - The same edge moves the FSM to X_START and sets xmit_busyH=1.
  - xmitH while xmit_busyH=1 is ignored: no queuing and no corruption of the frame in flight.
- All outputs are registered. uart_xmitH changes only at bit-cell boundaries.
- States:
  - X_IDLE: line=1. Wait for accept.
  - X_START: line=0 for BIT_CYCLES cycles, then go to X_DATA with bit count 0.
  - X_DATA: line=shift[0] for BIT_CYCLES cycles, then shift right and increment the bit count. After WORD_LEN bits go to X_PARITY if PARITY_EN, else X_STOP.
  - X_PARITY: line=parity bit for BIT_CYCLES cycles, then go to X_STOP.
  - X_STOP: line=1 for STOP_BITS*BIT_CYCLES cycles, then go to X_IDLE.
- Parity bit = XOR of the data bits; inverted when PARITY_ODD=1.
- Frame timing:
  - The start bit begins on the edge after the accept edge, i.e. 1 cycle latency.
  - Frame length = (1 + WORD_LEN + PARITY_EN + STOP_BITS) * BIT_CYCLES cycles.
- Completion:
  - On the X_STOP-to-X_IDLE edge, xmit_busyH→0 and xmit_doneH=1 for exactly one cycle.
  - A new xmitH in that same cycle is accepted. The next start bit immediately follows the last stop cycle, with no idle gap.
- Bit-cell counter: 4 bits, reset to 0 at every bit boundary. It must not wrap inside a cell. Terminal count is BIT_CYCLES-1.
- Illegal or unused state encodings recover to X_IDLE with line=1 on the next clock.
- xmit_dataH changes after the accept edge have no effect on the frame.

Test Plan:
- Reset then idle: assert sys_rst mid-cycle → uart_xmitH=1, busy=0, done=0 asynchronously; 100 idle cycles keep the line high.
- Default frame: xmitH pulse with 8'hA5 → line low for cycles 1-16, then bits 1,0,1,0,0,1,0,1 each 16 cycles, high for 16 cycles. done pulses at cycle 161, busy high for 160 cycles.
- Loopback: feed uart_xmitH to u_rec, send 8'h00, 8'hFF, 8'h55, 8'h3C back-to-back (xmitH held high) → u_rec rec_dataH matches each byte with rec_readyH per frame and no idle gaps between frames.
- Busy rejection: xmitH with 8'h12, then xmitH with 8'h34 at cycle 50 → only 8'h12 is transmitted; exactly one done pulse.
- Parity/stop: PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2, data 8'h07 → parity bit 0 after the data bits, then 32 high cycles; frame 192 cycles.
- Reset mid-frame: reset at cycle 70 of a frame → line high immediately, no done pulse. A new xmitH after reset release yields a clean full frame.
